chunk_pingpong_sched: RTL

CHUNK_PINGPONG_SCHED -- requirements
Module: chunk_pingpong_sched

---
 rtl/chunk_pingpong_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/chunk_pingpong_sched.sv
// rtl/chunk_pingpong_sched.sv - ping-pong BRAM bank scheduler overlapping DDR load/writeback with LBM compute
module chunk_pingpong_sched #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_chunks,
    input  logic              ddr_done,
    input  logic              lbm_done,
    input  logic [ADDR_W-1:0] ddr_addr,
    input  logic [ADDR_W-1:0] lbm_addr,
    input  logic              ddr_wen,
    input  logic              lbm_wen,
    output logic [ADDR_W-1:0] bank0_addr,
    output logic [ADDR_W-1:0] bank1_addr,
    output logic              bank0_we,
    output logic              bank1_we,
    output logic              xfer_bank,
    output logic              ddr_start,
    output logic              ddr_ld,
    output logic              ddr_wb,
    output logic [CNT_W-1:0]  ld_chunk,
    output logic [CNT_W-1:0]  wb_chunk,
    output logic [CNT_W-1:0]  lbm_chunk,
    output logic              lbm_start,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   n_reg, n_nx;
    logic [CNT_W-1:0]   phase, phase_nx;
    logic               ddr_ok, ddr_ok_nx, lbm_ok, lbm_ok_nx;
    logic               xfer_nx, ddr_start_nx, ddr_ld_nx, ddr_wb_nx, lbm_start_nx, busy_nx, done_nx;
    logic [CNT_W-1:0]   ld_chunk_nx, wb_chunk_nx, lbm_chunk_nx;
    logic               go_run;
    logic [CNT_W-1:0]   k_nx;
    logic               bank_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            n_reg     <= '0;
            phase     <= '0;
            ddr_ok    <= 1'b0;
            lbm_ok    <= 1'b0;
            xfer_bank <= 1'b0;
            ddr_start <= 1'b0;
            ddr_ld    <= 1'b0;
            ddr_wb    <= 1'b0;
            ld_chunk  <= '0;
            wb_chunk  <= '0;
            lbm_chunk <= '0;
            lbm_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            n_reg     <= n_nx;
            phase     <= phase_nx;
            ddr_ok    <= ddr_ok_nx;
            lbm_ok    <= lbm_ok_nx;
            xfer_bank <= xfer_nx;
            ddr_start <= ddr_start_nx;
            ddr_ld    <= ddr_ld_nx;
            ddr_wb    <= ddr_wb_nx;
            ld_chunk  <= ld_chunk_nx;
            wb_chunk  <= wb_chunk_nx;
            lbm_chunk <= lbm_chunk_nx;
            lbm_start <= lbm_start_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        n_nx         = n_reg;
        phase_nx     = phase;
        ddr_ok_nx    = ddr_ok;
        lbm_ok_nx    = lbm_ok;
        xfer_nx      = xfer_bank;
        ddr_start_nx = 1'b0;
        lbm_start_nx = 1'b0;
        done_nx      = 1'b0;
        ddr_ld_nx    = ddr_ld;
        ddr_wb_nx    = ddr_wb;
        ld_chunk_nx  = ld_chunk;
        wb_chunk_nx  = wb_chunk;
        lbm_chunk_nx = lbm_chunk;
        busy_nx      = busy;
        go_run       = 1'b0;
        k_nx         = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    n_nx    = num_chunks;
                    xfer_nx = 1'b0;
                    if (num_chunks != '0) begin
                        state_nx     = S_FILL;
                        ddr_start_nx = 1'b1;
                        ddr_ld_nx    = 1'b1;
                        ddr_wb_nx    = 1'b0;
                        ld_chunk_nx  = '0;
                        busy_nx      = 1'b1;
                    end else begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (ddr_done) begin
                    go_run = 1'b1;
                    k_nx   = CNT_W'(1);
                end
            end
            S_RUN: begin
                // Done pulses from the current cycle count as if already latched
                if ((ddr_ok || ddr_done) && (lbm_ok || lbm_done)) begin
                    if (phase < n_reg) begin
                        go_run = 1'b1;
                        k_nx   = phase + CNT_W'(1);
                    end else begin
                        state_nx     = S_FLUSH;
                        xfer_nx      = ~xfer_bank;
                        ddr_start_nx = 1'b1;
                        ddr_ld_nx    = 1'b0;
                        ddr_wb_nx    = 1'b1;
                        wb_chunk_nx  = n_reg - CNT_W'(1);
                    end
                end else begin
                    ddr_ok_nx = ddr_ok | ddr_done;
                    lbm_ok_nx = lbm_ok | lbm_done;
                end
            end
            S_FLUSH: begin
                if (ddr_done) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (go_run) begin
            state_nx     = S_RUN;
            phase_nx     = k_nx;
            xfer_nx      = ~xfer_bank;
            lbm_start_nx = 1'b1;
            lbm_chunk_nx = k_nx - CNT_W'(1);
            ddr_ld_nx    = (k_nx < n_reg);
            ld_chunk_nx  = k_nx;
            ddr_wb_nx    = (k_nx >= CNT_W'(2));
            wb_chunk_nx  = (k_nx >= CNT_W'(2)) ? k_nx - CNT_W'(2) : '0;
            ddr_start_nx = ddr_ld_nx | ddr_wb_nx;
            ddr_ok_nx    = ~(ddr_ld_nx | ddr_wb_nx);
            lbm_ok_nx    = 1'b0;
        end
    end

    // Bank ownership follows xfer_bank; writes are blocked whenever no run is active
    assign bank_en    = (state == S_FILL) || (state == S_RUN) || (state == S_FLUSH);
    assign bank0_addr = xfer_bank ? lbm_addr : ddr_addr;
    assign bank1_addr = xfer_bank ? ddr_addr : lbm_addr;
    assign bank0_we   = bank_en & (xfer_bank ? lbm_wen : ddr_wen);
    assign bank1_we   = bank_en & (xfer_bank ? ddr_wen : lbm_wen);

endmodule
